// File: rtl/sparse_pkg.sv
// rtl/sparse_pkg.sv - shared sizes, COO entry / product job types and FSM states
//
// Purpose: single home for the sparse_mm geometry (M, N, K, value width, list
//          capacity) and the types that cross the scheduler boundary.
// Contents:
//   entry_t        COO entry {row, col, val}
//   job_t          product job {row i, col k, a_val, b_val}
//   sched_state_e  scheduler FSM states
package sparse_pkg;

  localparam int DATA_SIZE     = 16;
  localparam int M             = 4;
  localparam int N             = 4;
  localparam int K             = 4;
  localparam int MAX_LIST_SIZE = 30;

  localparam int MAX_DIM = (M > N) ? ((M > K) ? M : K) : ((N > K) ? N : K);
  localparam int COORD_W = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

  // a_count/b_count must be able to express MAX_LIST_SIZE+1 so the clamp can act
  localparam int CNT_W   = $clog2(MAX_LIST_SIZE + 1);
  localparam int IDX_W   = (MAX_LIST_SIZE > 1) ? $clog2(MAX_LIST_SIZE) : 1;
  localparam int JCNT_W  = $clog2(MAX_LIST_SIZE * MAX_LIST_SIZE + 1);

  typedef struct packed {
    logic [COORD_W-1:0]   row;
    logic [COORD_W-1:0]   col;
    logic [DATA_SIZE-1:0] val;
  } entry_t;

  typedef struct packed {
    logic [COORD_W-1:0]   row;
    logic [COORD_W-1:0]   col;
    logic [DATA_SIZE-1:0] a_val;
    logic [DATA_SIZE-1:0] b_val;
  } job_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/sparse_mm_scheduler.sv
// rtl/sparse_mm_scheduler.sv - COO pair walker emitting product jobs to the MAC array
//
// Purpose: on start, walks every (A entry, B entry) pair once, one compare per
//          cycle, and emits a job for each pair whose inner index matches.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               begin a scan (only honoured in IDLE)
//   a_list, b_list      COO entry arrays, held stable while busy
//   a_count, b_count    valid entries per list (clamped to MAX_LIST_SIZE)
//   job_valid/job_ready product job stream handshake, job is the payload
//   busy                scan in progress
//   done                one-cycle pulse at scan end
//   job_count           jobs accepted in the current/last scan
module sparse_mm_scheduler
  import sparse_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  entry_t            a_list [MAX_LIST_SIZE],
  input  entry_t            b_list [MAX_LIST_SIZE],
  input  logic [CNT_W-1:0]  a_count,
  input  logic [CNT_W-1:0]  b_count,
  output logic              job_valid,
  input  logic              job_ready,
  output job_t              job,
  output logic              busy,
  output logic              done,
  output logic [JCNT_W-1:0] job_count
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_LIST_SIZE);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [JCNT_W-1:0] JCNT_ONE = JCNT_W'(1);

  sched_state_e      state_q, state_d;
  logic [CNT_W-1:0]  a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0]  b_cnt_q, b_cnt_d;
  logic [IDX_W-1:0]  ai_q, ai_d;
  logic [IDX_W-1:0]  bi_q, bi_d;
  job_t              job_q, job_d;
  logic              job_valid_q, job_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [JCNT_W-1:0] job_count_q, job_count_d;

  entry_t           a_cur, b_cur;
  logic             is_match;
  logic             b_at_end, last_pair;
  logic [IDX_W-1:0] ai_nxt, bi_nxt;
  logic [CNT_W-1:0] a_clamp, b_clamp;

  assign a_cur    = a_list[ai_q];
  assign b_cur    = b_list[bi_q];
  assign is_match = (a_cur.col == b_cur.row);

  assign b_at_end  = (CNT_W'(bi_q) == (b_cnt_q - CNT_ONE));
  assign last_pair = b_at_end && (CNT_W'(ai_q) == (a_cnt_q - CNT_ONE));

  // Row-major walk over the pair space: B index is the fast one
  always_comb begin
    ai_nxt = ai_q;
    bi_nxt = bi_q + IDX_ONE;
    if (b_at_end) begin
      ai_nxt = ai_q + IDX_ONE;
      bi_nxt = '0;
    end
  end

  assign a_clamp = (a_count > CNT_MAX) ? CNT_MAX : a_count;
  assign b_clamp = (b_count > CNT_MAX) ? CNT_MAX : b_count;

  always_comb begin
    state_d     = state_q;
    a_cnt_d     = a_cnt_q;
    b_cnt_d     = b_cnt_q;
    ai_d        = ai_q;
    bi_d        = bi_q;
    job_d       = job_q;
    job_valid_d = job_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    job_count_d = job_count_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_cnt_d     = a_clamp;
          b_cnt_d     = b_clamp;
          ai_d        = '0;
          bi_d        = '0;
          job_count_d = '0;
          busy_d      = 1'b1;
          state_d     = ((a_clamp == '0) || (b_clamp == '0)) ? S_DONE : S_SCAN;
        end
      end

      S_SCAN: begin
        if (is_match) begin
          job_d       = '{row: a_cur.row, col: b_cur.col, a_val: a_cur.val, b_val: b_cur.val};
          job_valid_d = 1'b1;
          state_d     = S_EMIT;
        end else if (last_pair) begin
          // indices stay put on the final pair so the list muxes never go out of range
          state_d = S_DONE;
        end else begin
          ai_d = ai_nxt;
          bi_d = bi_nxt;
        end
      end

      S_EMIT: begin
        if (job_valid_q && job_ready) begin
          job_valid_d = 1'b0;
          job_count_d = job_count_q + JCNT_ONE;
          if (last_pair) begin
            state_d = S_DONE;
          end else begin
            ai_d    = ai_nxt;
            bi_d    = bi_nxt;
            state_d = S_SCAN;
          end
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_cnt_q     <= '0;
      b_cnt_q     <= '0;
      ai_q        <= '0;
      bi_q        <= '0;
      job_q       <= '0;
      job_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      job_count_q <= '0;
    end else begin
      state_q     <= state_d;
      a_cnt_q     <= a_cnt_d;
      b_cnt_q     <= b_cnt_d;
      ai_q        <= ai_d;
      bi_q        <= bi_d;
      job_q       <= job_d;
      job_valid_q <= job_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      job_count_q <= job_count_d;
    end
  end

  assign job_valid = job_valid_q;
  assign job       = job_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign job_count = job_count_q;

endmodule

// File: tb/tb_sparse_mm_scheduler.sv
// tb/tb_sparse_mm_scheduler.sv - self-checking bench for sparse_mm_scheduler
module tb_sparse_mm_scheduler;
  import sparse_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  entry_t            a_list [MAX_LIST_SIZE];
  entry_t            b_list [MAX_LIST_SIZE];
  logic [CNT_W-1:0]  a_count;
  logic [CNT_W-1:0]  b_count;
  logic              job_valid;
  logic              job_ready;
  job_t              job;
  logic              busy;
  logic              done;
  logic [JCNT_W-1:0] job_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sparse_mm_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_list    (a_list),
    .b_list    (b_list),
    .a_count   (a_count),
    .b_count   (b_count),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job       (job),
    .busy      (busy),
    .done      (done),
    .job_count (job_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic entry_t mk(input int r, input int c, input int v);
    entry_t e;
    e.row = COORD_W'(r);
    e.col = COORD_W'(c);
    e.val = DATA_SIZE'(v);
    return e;
  endfunction

  task automatic clear_lists();
    for (int i = 0; i < MAX_LIST_SIZE; i++) begin
      a_list[i] = '0;
      b_list[i] = '0;
    end
  endtask

  task automatic load_case1();
    clear_lists();
    a_list[0] = mk(0, 1, 3);
    a_list[1] = mk(2, 1, 5);
    b_list[0] = mk(1, 3, 7);
    a_count   = CNT_W'(2);
    b_count   = CNT_W'(1);
  endtask

  task automatic load_random(input int ac, input int bc);
    for (int i = 0; i < MAX_LIST_SIZE; i++) begin
      a_list[i] = mk($urandom_range(0, M - 1), $urandom_range(0, N - 1), $urandom_range(0, 65535));
      b_list[i] = mk($urandom_range(0, N - 1), $urandom_range(0, K - 1), $urandom_range(0, 65535));
    end
    a_count = CNT_W'(ac);
    b_count = CNT_W'(bc);
  endtask

  // Reference: every (A,B) pair in list order, a job wherever A's column equals B's row.
  // Expected latency: one edge per pair, start and done edges, plus one edge per job and per stall.
  task automatic run_scan(input string tag, input int stall_first, input bit rnd_ready,
                          input int restart_at);
    job_t exp_q[$];
    int   ac, bc, exp_jobs, edges, stalls, njobs;
    bit   saw_done, rdy;
    ac = (int'(a_count) > MAX_LIST_SIZE) ? MAX_LIST_SIZE : int'(a_count);
    bc = (int'(b_count) > MAX_LIST_SIZE) ? MAX_LIST_SIZE : int'(b_count);
    for (int i = 0; i < ac; i++)
      for (int j = 0; j < bc; j++)
        if (a_list[i].col == b_list[j].row)
          exp_q.push_back('{row: a_list[i].row, col: b_list[j].col,
                            a_val: a_list[i].val, b_val: b_list[j].val});
    exp_jobs = exp_q.size();

    @(negedge clk);
    start     = 1'b1;
    job_ready = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start    = 1'b0;
    stalls   = 0;
    njobs    = 0;
    saw_done = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (done) begin
        saw_done = 1'b1;
        break;
      end
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      start = (cyc == restart_at);
      rdy   = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (job_valid) begin
        if (njobs == 0 && stalls < stall_first) rdy = 1'b0;
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_job"}, 64'd1, 64'd0);
        end else begin
          chk({tag, "_job"}, 64'(job), 64'(exp_q[0]));
        end
        if (rdy) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          njobs++;
        end else begin
          stalls++;
        end
      end
      job_ready = rdy;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start     = 1'b0;
    job_ready = 1'b1;
    chk({tag, "_done_seen"}, 64'(saw_done), 64'd1);
    chk({tag, "_latency"}, 64'(edges), 64'(ac * bc + 2 + exp_jobs + stalls));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_job_count"}, 64'(job_count), 64'(exp_jobs));
    chk({tag, "_jobs_left"}, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_count_hold"}, 64'(job_count), 64'(exp_jobs));
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    job_ready = 1'b1;
    a_count   = '0;
    b_count   = '0;
    clear_lists();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    chk("rst_valid", 64'(job_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(job_count), 64'd0);
    chk("rst_job", 64'(job), 64'd0);

    load_case1();
    run_scan("case1", 0, 1'b0, -1);

    clear_lists();
    a_list[0] = mk(0, 0, 2);
    b_list[0] = mk(1, 1, 4);
    a_count   = CNT_W'(1);
    b_count   = CNT_W'(1);
    run_scan("nomatch", 0, 1'b0, -1);

    load_random(0, 5);
    run_scan("a_zero", 0, 1'b0, -1);

    load_random(31, 2);
    run_scan("a_clamp", 0, 1'b1, -1);

    load_case1();
    run_scan("stall4", 4, 1'b0, -1);

    load_case1();
    run_scan("restart", 0, 1'b0, 2);

    // reset while a job is waiting for acceptance
    load_case1();
    @(negedge clk);
    start     = 1'b1;
    job_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && !job_valid; c++) @(negedge clk);
    chk("mid_reach_emit", 64'(job_valid), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_valid", 64'(job_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_count", 64'(job_count), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    job_ready = 1'b1;
    run_scan("after_rst", 0, 1'b0, -1);

    for (int r = 0; r < 8; r++) begin
      load_random($urandom_range(0, 31), $urandom_range(0, 31));
      run_scan("random", $urandom_range(0, 3), 1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
